fre_bin2bcd: RTL and testbench
==============================

// Module: fre_bin2bcd
// PURPOSE
//  Downstream of the direct-count frequency meter: takes its 32-bit binary
//  frequency result (Hz) and converts it to packed BCD for the 7-segment display.
//  Uses a sequential shift-add-3 (double-dabble) engine, one bit per clk.
//  Starts a conversion only when a new, stable frequency value appears.
//  Also reports the number of significant digits, for leading-zero blanking.
// PARAMETERS
//  W       32  binary input width
//  DIGITS  10  BCD output digits; must satisfy 10^DIGITS > 2^W
// PORTS
//  clk        in   1           system clock, 100 MHz
//  rst_n      in   1           asynchronous, active-low reset
//  fre        in   W           binary frequency from meter; may change on any edge
//  bcd        out  4*DIGITS    packed BCD result, digit 0 in [3:0]
//  digit_cnt  out  4           significant digits in bcd, range 1..DIGITS
//  busy       out  1           high while in SHIFT or DONE
//  valid      out  1           one-clk pulse; bcd/digit_cnt updated that cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): bcd=0, digit_cnt=1, busy=0, valid=0, state=IDLE,
//   sample regs s1/s2=0, last=0. Reset mid-conversion aborts it; no valid.
//  Input sampling every clk: s1<=fre; s2<=s1.
//  FSM:
//   IDLE  -> SHIFT  when s1==s2 && s2!=last.
//            Load shreg=s2, work=0, last=s2, cnt=0.
//   SHIFT -> one step per clk. Each digit of work >=5 gets +3,
//            then {work,shreg}<<=1. At cnt==W-1 go to DONE, else cnt++.
//   DONE  -> IDLE. Register bcd<=work; register digit_cnt;
//            valid=1 for exactly this one cycle.
//  Latency: fre changes before sampling edge E0 -> bcd/valid visible after
//   edge E0+W+3 (35 clks for W=32). Throughput: one result per W+2 clks.
//  fre changes during SHIFT/DONE are ignored. Back in IDLE, the s1/s2 vs last
//   compare retriggers, so the newest stable value is always converted.
//  fre equal to last: no conversion, no valid. This includes 0 after reset,
//   since bcd=0 already.
//  Unstable input (s1!=s2 each clk) holds IDLE.
//  digit_cnt = index of the highest nonzero digit + 1; value 0 gives 1.
//  Computed combinationally from work and registered in DONE.
//  Add-3 on each digit is 4-bit with no carry out, since the digit is <=9
//   before the adjust. Shift carries digit i MSB into digit i+1 LSB; the MSB of
//   the top digit is dropped, which is guaranteed 0 by the DIGITS constraint.
//  cnt width is $clog2(W); it must not wrap before W-1.
//  bcd and digit_cnt hold their value between valid pulses.
// STRUCTURE
//  Package fre_disp_pkg: W_FRE=32, BCD_DIGITS=10, state enum
//   {IDLE,SHIFT,DONE} (2-bit), BCD_W=4*BCD_DIGITS.
//  Sub-module bcd_digit_adj: combinational 4-bit (d>=5 ? d+3 : d), instanced
//   DIGITS times via generate.
//  Top holds the sampler, FSM, shift registers, counter and digit_cnt encoder.
// TESTING
//  1 fre=12345678 held -> after 35 clks valid pulses once; bcd=40'h0012345678,
//    digit_cnt=8; no further valid while fre is held.
//  2 fre=32'hFFFFFFFF -> bcd=40'h4294967295, digit_cnt=10.
//  3 Reset, fre=0 held -> no valid ever; bcd=0, digit_cnt=1, busy=0.
//    Then fre=5 -> bcd=40'h5, digit_cnt=1.
//  4 fre=1000, then fre=999 10 clks later (mid-SHIFT) -> valid with 0x1000,
//    digit_cnt=4; then a second valid W+2 clks later with 0x999, digit_cnt=3.
//  5 fre=777 then rst_n low at SHIFT cnt=15 -> outputs return to reset values,
//    no valid. After release the conversion restarts; valid with 0x777.
//  6 fre toggling every clk between 1 and 2 -> no conversion, busy stays 0.
//    Then holding 2 -> valid with bcd=0x2.
//  Scoreboard: every valid checks bcd against a reference integer->BCD conversion
//   of last; a 200-value random sweep is run with fre held >=40 clks each.

Source files
------------

// File: rtl/fre_bin2bcd_pkg.sv
// Shared constants and state encoding for the frequency-display BCD converter.
package fre_disp_pkg;
   localparam int unsigned W_FRE      = 32;
   localparam int unsigned BCD_DIGITS = 10;
   localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;
endpackage

// File: rtl/fre_bin2bcd_if.sv
// Frequency-in / BCD-out bundle between the meter side and the display converter.
interface fre_bin2bcd_if #(
   parameter int unsigned W      = fre_disp_pkg::W_FRE,
   parameter int unsigned DIGITS = fre_disp_pkg::BCD_DIGITS
);
   logic [W-1:0]          fre;
   logic [4*DIGITS-1:0]   bcd;
   logic [3:0]            digit_cnt;
   logic                  busy;
   logic                  valid;

   modport master (
      output fre,
      input  bcd,
      input  digit_cnt,
      input  busy,
      input  valid
   );

   modport slave (
      input  fre,
      output bcd,
      output digit_cnt,
      output busy,
      output valid
   );
endinterface

// File: rtl/fre_bin2bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj (
   input  logic [3:0] i_d,
   output logic [3:0] o_d
);
   always_comb begin
      o_d = i_d;
      if (i_d >= 4'd5) o_d = i_d + 4'd3;
   end
endmodule

// File: rtl/fre_bin2bcd.sv
// Sequential binary-to-BCD converter for the frequency meter result, one bit per clk;
// converts only when a new value has been stable for two samples.
module fre_bin2bcd
   import fre_disp_pkg::*;
#(
   parameter int unsigned W      = W_FRE,
   parameter int unsigned DIGITS = BCD_DIGITS
) (
   input  logic          clk,
   input  logic          rst_n,
   fre_bin2bcd_if.slave  bus
);
   localparam int unsigned   BW       = 4 * DIGITS;
   localparam int unsigned   CW       = $clog2(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   state_t         r_state;
   logic [W-1:0]   r_s1;
   logic [W-1:0]   r_s2;
   logic [W-1:0]   r_last;
   logic [W-1:0]   r_shreg;
   logic [BW-1:0]  r_work;
   logic [BW-1:0]  r_bcd;
   logic [CW-1:0]  r_cnt;
   logic [3:0]     r_digit_cnt;
   logic           r_busy;
   logic           r_valid;
   logic [BW-1:0]  w_adj;
   logic [3:0]     w_digit_cnt;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_d (r_work[4*g +: 4]),
         .o_d (w_adj[4*g +: 4])
      );
   end

   // Highest nonzero digit wins; an all-zero value still shows one digit.
   always_comb begin
      w_digit_cnt = 4'd1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (r_work[4*i +: 4] != 4'd0) w_digit_cnt = 4'(i + 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_s1        <= '0;
         r_s2        <= '0;
         r_last      <= '0;
         r_shreg     <= '0;
         r_work      <= '0;
         r_cnt       <= '0;
         r_bcd       <= '0;
         r_digit_cnt <= 4'd1;
         r_busy      <= 1'b0;
         r_valid     <= 1'b0;
      end else begin
         r_s1    <= bus.fre;
         r_s2    <= r_s1;
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_s1 == r_s2 && r_s2 != r_last) begin
                  r_shreg <= r_s2;
                  r_work  <= '0;
                  r_last  <= r_s2;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               // Top-digit MSB falls off the truncation; it is always 0 for legal DIGITS.
               r_work  <= BW'({w_adj, r_shreg[W-1]});
               r_shreg <= {r_shreg[W-2:0], 1'b0};
               if (r_cnt == CNT_LAST) r_state <= DONE;
               else                   r_cnt   <= r_cnt + 1'b1;
            end
            DONE: begin
               r_bcd       <= r_work;
               r_digit_cnt <= w_digit_cnt;
               r_valid     <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.bcd       = r_bcd;
   assign bus.digit_cnt = r_digit_cnt;
   assign bus.busy      = r_busy;
   assign bus.valid     = r_valid;
endmodule

// File: tb/tb_fre_bin2bcd.sv
// Scoreboard bench for fre_bin2bcd: directed vectors plus a random sweep against a
// divide-by-ten reference.
module tb_fre_bin2bcd;
   typedef struct {
      logic [39:0] bcd;
      logic [3:0]  dcnt;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;
   exp_t        q[$];
   logic [31:0] m_last = '0;

   fre_bin2bcd_if bus ();

   fre_bin2bcd dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [39:0] ref_bcd(input logic [31:0] v);
      logic [63:0] x;
      logic [39:0] r;
      x = {32'd0, v};
      r = '0;
      for (int i = 0; i < 10; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [3:0] ref_dcnt(input logic [31:0] v);
      logic [63:0] x;
      logic [3:0]  n;
      x = {32'd0, v};
      n = 4'd1;
      while (x >= 10) begin
         x = x / 10;
         n = n + 4'd1;
      end
      return n;
   endfunction

   task automatic push(input logic [39:0] b, input logic [3:0] d, input int due);
      exp_t e;
      e.bcd  = b;
      e.dcnt = d;
      e.due  = due;
      q.push_back(e);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.valid !== 1'b0) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got bcd %0h dcnt %0d expected no valid (cyc %0d)",
                     bus.bcd, bus.digit_cnt, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("bcd", 64'(bus.bcd), 64'(e.bcd));
            chk("digit_cnt", 64'(bus.digit_cnt), 64'(e.dcnt));
            if (e.due != 0) chk("latency_cycle", 64'(cyc), 64'(e.due));
         end
      end
   end

   initial begin
      int c;
      logic [31:0] v;
      bus.fre = '0;
      rst_n   = 1'b0;
      wait_clks(3);
      chk("reset_bcd", 64'(bus.bcd), 64'd0);
      chk("reset_dcnt", 64'(bus.digit_cnt), 64'd1);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_valid", 64'(bus.valid), 64'd0);
      rst_n = 1'b1;

      // Zero after reset equals last: nothing to convert.
      wait_clks(50);
      chk("zero_hold_bcd", 64'(bus.bcd), 64'd0);
      chk("zero_hold_dcnt", 64'(bus.digit_cnt), 64'd1);
      chk("zero_hold_busy", 64'(bus.busy), 64'd0);
      bus.fre = 32'd5; c = cyc;
      push(40'h5, 4'd1, c + 36);
      wait_clks(40);

      bus.fre = 32'd12345678; c = cyc;
      push(40'h0012345678, 4'd8, c + 36);
      wait_clks(140);

      bus.fre = 32'hFFFF_FFFF; c = cyc;
      push(40'h4294967295, 4'd10, c + 36);
      wait_clks(40);

      // Change mid-conversion: first value finishes, newest value follows back-to-back.
      bus.fre = 32'd1000; c = cyc;
      push(40'h1000, 4'd4, c + 36);
      wait_clks(10);
      bus.fre = 32'd999;
      push(40'h999, 4'd3, c + 70);
      wait_clks(80);

      bus.fre = 32'd777;
      wait_clks(17);
      chk("busy_mid_shift", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midreset_bcd", 64'(bus.bcd), 64'd0);
      chk("midreset_dcnt", 64'(bus.digit_cnt), 64'd1);
      chk("midreset_busy", 64'(bus.busy), 64'd0);
      chk("midreset_valid", 64'(bus.valid), 64'd0);
      wait_clks(2);
      rst_n = 1'b1; c = cyc;
      push(40'h777, 4'd3, c + 36);
      wait_clks(40);

      for (int i = 0; i < 40; i++) begin
         chk("toggle_busy", 64'(bus.busy), 64'd0);
         bus.fre = (i % 2 == 0) ? 32'd2 : 32'd1;
         @(negedge clk);
      end
      bus.fre = 32'd2; c = cyc;
      push(40'h2, 4'd1, c + 36);
      wait_clks(40);
      m_last = 32'd2;

      for (int k = 0; k < 200; k++) begin
         v = (k % 4 == 0) ? 32'($urandom_range(0, 999)) : $urandom;
         if (k % 25 == 24) v = m_last;
         bus.fre = v; c = cyc;
         if (v != m_last) push(ref_bcd(v), ref_dcnt(v), c + 36);
         m_last = v;
         wait_clks(40);
      end

      wait_clks(5);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
